// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory responder: bus widths, FSM state
// encoding, the data returned for out-of-range reads and an address range check.
package mem_if_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int BURST_W = 3;
  localparam int WAIT_W  = 4;

  localparam logic [DATA_W-1:0] OOR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (32'(addr) < depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/beat bus between the controller datapath (master) and the memory
// responder (slave). fsm_state exposes the responder FSM for observation.
interface mem_responder_if;
  import mem_if_pkg::*;

  // Handshake: a request is accepted on a clk edge where req_valid & req_ready;
  // the master holds req_valid and all req_* fields stable until then. After
  // acceptance, beat_ack pulses once per beat; rsp_done marks the final beat.
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [BURST_W-1:0]  req_len;
  logic [DATA_W-1:0]   req_wdata;
  logic                beat_ack;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_done;
  logic                err;
  logic                busy;
  state_t              fsm_state;

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata,
    input  req_ready, beat_ack, rsp_rdata, rsp_done, err, busy, fsm_state
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata,
    output req_ready, beat_ack, rsp_rdata, rsp_done, err, busy, fsm_state
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM: synchronous write, registered read. Only the
// read register is reset; the array contents survive reset.
module mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts single/burst read and write requests, inserts
// WAIT_STATES idle cycles, then streams one beat per cycle to or from mem_array.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             proc_rst,
  mem_responder_if.slave   bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              state;
  state_t              state_nxt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  len_q;
  logic [BURST_W-1:0]  beat_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                err_q;

  logic                accept;
  logic                in_beat;
  logic                last_beat;
  logic [ADDR_W-1:0]   beat_addr;
  logic [ADDR_W-1:0]   next_addr;
  logic                beat_oor;

  logic [ADDR_W-1:0]   ram_a;
  logic                ram_we;
  logic                ram_re;
  logic [DATA_W-1:0]   ram_rdata;

  assign accept    = bus.req_valid && (state == ST_IDLE);
  assign in_beat   = (state == ST_BEAT);
  assign last_beat = in_beat && (beat_cnt == len_q);
  assign beat_addr = addr_q + ADDR_W'(beat_cnt);
  assign next_addr = beat_addr + ADDR_W'(1);
  assign beat_oor  = !in_range(beat_addr, DEPTH);

  // The read register is loaded one cycle ahead of each read beat, so the
  // port looks at the address of the beat that is about to start.
  always_comb begin
    ram_a  = beat_addr;
    ram_we = 1'b0;
    ram_re = 1'b0;
    case (state)
      ST_IDLE: ram_a = bus.req_addr;
      ST_WAIT: ram_a = addr_q;
      ST_BEAT: ram_a = we_q ? beat_addr : next_addr;
      default: ram_a = beat_addr;
    endcase
    if (in_beat && we_q) begin
      ram_we = !beat_oor;
    end else begin
      ram_re = in_range(ram_a, DEPTH);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_BEAT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= WAIT_W'(1)) begin
          state_nxt = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (beat_cnt == len_q) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      state    <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q     <= bus.req_we;
        addr_q   <= bus.req_addr;
        len_q    <= bus.req_len;
        beat_cnt <= '0;
        wait_cnt <= WAIT_W'(WAIT_STATES);
        err_q    <= 1'b0;
      end
      if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (in_beat) begin
        err_q    <= err_q | beat_oor;
        beat_cnt <= last_beat ? '0 : beat_cnt + BURST_W'(1);
      end
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (proc_rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_a[AW-1:0]),
    .wdata (bus.req_wdata),
    .rdata (ram_rdata)
  );

  // err reflects an out-of-range beat in the same cycle it is acknowledged.
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.beat_ack  = in_beat;
  assign bus.rsp_done  = last_beat;
  assign bus.rsp_rdata = (in_beat && beat_oor) ? OOR_DATA : ram_rdata;
  assign bus.err       = err_q | (in_beat && beat_oor);
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with one wait state and one
// with none, sharing request fields; sel picks which instance sees req_valid.
module tb_mem_responder;
  import mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [2:0]  len = '0;
  logic [15:0] wdata = '0;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];
  logic        exp_err_q[$];

  mem_responder_if bus0();
  mem_responder_if bus1();

  assign bus0.req_valid = valid & ~sel;
  assign bus1.req_valid = valid & sel;
  assign bus0.req_we    = we;
  assign bus1.req_we    = we;
  assign bus0.req_addr  = addr;
  assign bus1.req_addr  = addr;
  assign bus0.req_len   = len;
  assign bus1.req_len   = len;
  assign bus0.req_wdata = wdata;
  assign bus1.req_wdata = wdata;

  mem_responder #(.DEPTH(256), .WAIT_STATES(1)) dut0 (.clk(clk), .proc_rst(rst), .bus(bus0));
  mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut1 (.clk(clk), .proc_rst(rst), .bus(bus1));

  logic        o_ready, o_ack, o_done, o_err, o_busy;
  logic [15:0] o_rdata;
  assign o_ready = sel ? bus1.req_ready : bus0.req_ready;
  assign o_ack   = sel ? bus1.beat_ack  : bus0.beat_ack;
  assign o_done  = sel ? bus1.rsp_done  : bus0.rsp_done;
  assign o_err   = sel ? bus1.err       : bus0.err;
  assign o_busy  = sel ? bus1.busy      : bus0.busy;
  assign o_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 16'(o_ready), 16'd1);
    chk({tag, "_busy"},  16'(o_busy),  16'd0);
    chk({tag, "_ack"},   16'(o_ack),   16'd0);
    chk({tag, "_done"},  16'(o_done),  16'd0);
    chk({tag, "_err"},   16'(o_err),   16'd0);
    chk({tag, "_rdata"}, o_rdata,      16'h0000);
  endtask

  // driver: write burst, beat k carries base+k; abort_at>=0 resets during that beat
  task automatic do_write(input logic [15:0] a, input logic [2:0] l,
                          input logic [15:0] base, input int abort_at);
    int k;
    int ws;
    ws = sel ? 0 : 1;
    k = 0;
    addr = a; len = l; we = 1'b1; wdata = base; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 1; c <= 30 && k <= int'(l); c++) begin
      if (o_ack) begin
        if (k == 0) chk("wr_latency", 16'(c), 16'(1 + ws));
        wdata = base + 16'(k);
        if (k == abort_at) begin
          rst = 1'b1;
          #1;
          chk_reset_outputs("abort");
          tick();
          rst = 1'b0;
          we = 1'b0;
          return;
        end
        chk("wr_done", 16'(o_done), 16'(k == int'(l)));
        k++;
      end
      tick();
    end
    chk("wr_beats", 16'(k), 16'(int'(l) + 1));
    chk("wr_idle_ready", 16'(o_ready), 16'd1);
    we = 1'b0;
  endtask

  // driver + scoreboard: read burst checked against exp_q / exp_err_q;
  // poke raises a write request during beats 1..2 that must be ignored
  task automatic do_read(input logic [15:0] a, input logic [2:0] l, input bit poke);
    int k;
    int ws;
    int first;
    logic [15:0] e;
    logic        ee;
    ws = sel ? 0 : 1;
    k = 0;
    first = 0;
    addr = a; len = l; we = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 1; c <= 30 && k <= int'(l); c++) begin
      if (o_ack) begin
        if (k == 0) begin
          first = c;
          chk("rd_latency", 16'(c), 16'(1 + ws));
        end else begin
          chk("rd_back_to_back", 16'(c), 16'(first + k));
        end
        e  = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        ee = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'b0;
        chk("rd_data", o_rdata, e);
        chk("rd_err", 16'(o_err), 16'(ee));
        chk("rd_done", 16'(o_done), 16'(k == int'(l)));
        if (poke && k == 1) begin
          valid = 1'b1; we = 1'b1; addr = a + 16'd1; len = 3'd0; wdata = 16'hBAD0;
        end
        if (poke && k == 2) begin
          valid = 1'b0; we = 1'b0;
        end
        k++;
      end
      tick();
    end
    chk("rd_beats", 16'(k), 16'(int'(l) + 1));
    chk("rd_idle_busy", 16'(o_busy), 16'd0);
    chk("rd_idle_ready", 16'(o_ready), 16'd1);
    exp_q.delete();
    exp_err_q.delete();
  endtask

  task automatic expect_beat(input logic [15:0] d, input logic e);
    exp_q.push_back(d);
    exp_err_q.push_back(e);
  endtask

  initial begin
    // reset values on both instances
    repeat (3) tick();
    sel = 1'b0; #1;
    chk_reset_outputs("rst0");
    chk("rst0_state", 16'(bus0.fsm_state), 16'(ST_IDLE));
    sel = 1'b1; #1;
    chk_reset_outputs("rst1");
    rst = 1'b0;
    sel = 1'b0;
    tick();

    // single write then read, one wait state
    do_write(16'h0010, 3'd0, 16'hA5A5, -1);
    expect_beat(16'hA5A5, 1'b0);
    do_read(16'h0010, 3'd0, 1'b0);

    // eight-beat burst write 1..8, read back
    do_write(16'h0020, 3'd7, 16'h0001, -1);
    for (int i = 1; i <= 8; i++) expect_beat(16'(i), 1'b0);
    do_read(16'h0020, 3'd7, 1'b0);

    // boundary: FE/FF in range, 100/101 out of range
    do_write(16'h00FE, 3'd1, 16'h1111, -1);
    expect_beat(16'h1111, 1'b0);
    expect_beat(16'h1112, 1'b0);
    expect_beat(16'hFFFF, 1'b1);
    expect_beat(16'hFFFF, 1'b1);
    do_read(16'h00FE, 3'd3, 1'b0);
    chk("err_sticky_idle", 16'(o_err), 16'd1);
    tick();
    chk("err_sticky_idle2", 16'(o_err), 16'd1);
    expect_beat(16'hA5A5, 1'b0);
    do_read(16'h0010, 3'd0, 1'b0);
    chk("err_cleared", 16'(o_err), 16'd0);

    // address wrap FFFF -> 0000
    do_write(16'h0000, 3'd0, 16'h5A5A, -1);
    expect_beat(16'hFFFF, 1'b1);
    expect_beat(16'h5A5A, 1'b1);
    do_read(16'hFFFF, 3'd1, 1'b0);

    // request raised while busy is ignored
    for (int i = 1; i <= 4; i++) expect_beat(16'(i), 1'b0);
    do_read(16'h0020, 3'd3, 1'b1);
    tick();
    chk("poke_not_accepted", 16'(o_busy), 16'd0);
    expect_beat(16'h0002, 1'b0);
    do_read(16'h0021, 3'd0, 1'b0);

    // reset during beat 3 of a write burst
    do_write(16'h0040, 3'd7, 16'h00C0, -1);
    do_write(16'h0040, 3'd7, 16'h00D0, 3);
    chk_reset_outputs("after_abort");
    expect_beat(16'h00D0, 1'b0);
    expect_beat(16'h00D1, 1'b0);
    expect_beat(16'h00D2, 1'b0);
    for (int i = 3; i <= 7; i++) expect_beat(16'h00C0 + 16'(i), 1'b0);
    do_read(16'h0040, 3'd7, 1'b0);

    // zero wait states
    sel = 1'b1;
    tick();
    do_write(16'h0005, 3'd0, 16'h1234, -1);
    expect_beat(16'h1234, 1'b0);
    do_read(16'h0005, 3'd0, 1'b0);
    do_write(16'h0030, 3'd2, 16'h0700, -1);
    expect_beat(16'h0700, 1'b0);
    expect_beat(16'h0701, 1'b0);
    expect_beat(16'h0702, 1'b0);
    do_read(16'h0030, 3'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
